// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the cascaded-counter command sequencer: mode codes,
// controller states and small helper functions.
package cnt_seq_pkg;

    localparam logic [1:0] MODE_UP  = 2'b00;
    localparam logic [1:0] MODE_DN  = 2'b01;
    localparam logic [1:0] MODE_UP3 = 2'b10;
    localparam logic [1:0] MODE_LD  = 2'b11;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        StIdle  = 3'd0,
        StClr   = 3'd1,
        StLoad  = 3'd2,
        StAck   = 3'd3,
        StRun   = 3'd4,
        StDrain = 3'd5,
        StDone  = 3'd6
    } state_e;

    // Increment that sticks at the all-ones value of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

    // Where a command goes once any counter clear has been issued.
    function automatic state_e cmd_dispatch(input logic [1:0] mode, input logic len_nz);
        if (mode == MODE_LD) begin
            return StLoad;
        end
        return len_nz ? StRun : StDone;
    endfunction

endpackage

// File: rtl/cnt_seq_fsm.sv
// Sequencer state register, next-state logic and the RUN-length down-counter.
// The length is captured at accept and consumed one per enable cycle.
module cnt_seq_fsm
    import cnt_seq_pkg::*;
#(
    parameter int unsigned LEN_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               accept,
    input  logic               cmd_clr,
    input  logic [1:0]         cmd_mode,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [1:0]         cur_mode,
    input  logic               halt,
    output logic [STATE_W-1:0] state
);

    state_e           state_q;
    logic [LEN_W-1:0] remaining_q;

    assign state = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        remaining_q <= cmd_len;
                        state_q     <= cmd_clr ? StClr
                                               : cmd_dispatch(cmd_mode, cmd_len != '0);
                    end
                end
                StClr:   state_q <= cmd_dispatch(cur_mode, remaining_q != '0);
                StLoad:  state_q <= StAck;
                StAck:   state_q <= StDone;
                StRun: begin
                    // The cycle that samples halt is still an enable cycle.
                    remaining_q <= remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1) || halt) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer driving the cascaded counter's control inputs.
// Build option CNT_SEQ_WRAP_STOP_EN: the first rco seen in RUN ends the run early.
module cnt_seq_ctrl
    import cnt_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LEN_W = 8,
    parameter int unsigned RCO_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_mode,
    input  logic [WIDTH-1:0] cmd_value,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_clr,
    input  logic             cmd_abort,
    output logic             cnt_enable,
    output logic [1:0]       cnt_mode,
    output logic [WIDTH-1:0] cnt_d,
    output logic             cnt_reset,
    input  logic             cnt_load,
    input  logic             cnt_rco,
    output logic             done,
    output logic             aborted,
    output logic             err,
    output logic [RCO_W-1:0] rco_count
);

    logic [STATE_W-1:0] state_bits;
    state_e             st;
    logic               accept;
    logic               wrap_stop;
    logic               halt;

    logic [1:0]       mode_q;
    logic [WIDTH-1:0] value_q;
    logic             aborted_q;
    logic             err_q;
    logic [RCO_W-1:0] rco_count_q;
    logic [RCO_W-1:0] rco_inc;

    assign st     = state_e'(state_bits);
    assign accept = cmd_valid && cmd_ready;

`ifdef CNT_SEQ_WRAP_STOP_EN
    assign wrap_stop = cnt_rco;
`else
    assign wrap_stop = 1'b0;
`endif

    assign halt = cmd_abort || wrap_stop;

    cnt_seq_fsm #(
        .LEN_W (LEN_W)
    ) u_fsm (
        .clk      (clk),
        .reset    (reset),
        .accept   (accept),
        .cmd_clr  (cmd_clr),
        .cmd_mode (cmd_mode),
        .cmd_len  (cmd_len),
        .cur_mode (mode_q),
        .halt     (halt),
        .state    (state_bits)
    );

    assign rco_inc = RCO_W'(sat_inc(32'(rco_count_q), RCO_W));

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q      <= MODE_UP;
            value_q     <= '0;
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            rco_count_q <= '0;
        end else if (accept) begin
            mode_q      <= cmd_mode;
            // cnt_d keeps showing the last load value across count commands.
            if (cmd_mode == MODE_LD) begin
                value_q <= cmd_value;
            end
            aborted_q   <= 1'b0;
            err_q       <= 1'b0;
            rco_count_q <= '0;
        end else begin
            unique case (st)
                StAck: begin
                    if (!cnt_load) begin
                        err_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (cmd_abort) begin
                        aborted_q <= 1'b1;
                    end
                    if (cnt_rco) begin
                        rco_count_q <= rco_inc;
                    end
                end
                // rco lags enable by a cycle, so the drain cycle still counts.
                StDrain: begin
                    if (cnt_rco) begin
                        rco_count_q <= rco_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = (st == StIdle);
    assign cnt_enable = (st == StRun) || (st == StLoad);
    assign cnt_mode   = mode_q;
    assign cnt_d      = value_q;
    assign cnt_reset  = reset || (st == StClr);
    assign done       = (st == StDone);
    assign aborted    = aborted_q;
    assign err        = err_q;
    assign rco_count  = rco_count_q;

endmodule
